// File: rtl/mental_sum_engine.sv
// Mental-arithmetic game: shows LFSR-drawn operands one at a time, then
// grades the player's answer against the running sum modulo MOD.
module mental_sum_engine #(
    parameter int NUM_W     = 5,
    parameter int MAX_TERMS = 8,
    parameter int TERM_CYC  = 10,
    parameter int ANS_CYC   = 40,
    parameter int RES_CYC   = 10,
    parameter int MOD       = 100,
    parameter int SCORE_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         n_terms,
    input  logic [7:0]         seed,
    input  logic [7:0]         answer,
    input  logic               answer_valid,
    output logic               busy,
    output logic [7:0]         disp_value,
    output logic [3:0]         bcd_tens,
    output logic [3:0]         bcd_units,
    output logic               correct,
    output logic               wrong,
    output logic               timeout,
    output logic [SCORE_W-1:0] score
);
    localparam int ACC_W = NUM_W + 4;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {IDLE, SHOW, GAP, WAIT_ANS, RESULT} state_t;

    state_t             r_state;
    logic [7:0]         r_lfsr;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_idx;
    logic [3:0]         r_nterms;
    logic [7:0]         r_disp;
    logic               r_correct, r_wrong, r_timeout;
    logic [SCORE_W-1:0] r_score;

    logic [7:0] w_lfsr_nxt;
    logic [7:0] w_mod;
    logic [3:0] w_nclamp;
    logic [7:0] w_clip;

    assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_mod      = 8'(r_acc % ACC_W'(MOD));
    assign w_nclamp   = (n_terms == 4'd0) ? 4'd1 :
                        (n_terms > 4'(MAX_TERMS)) ? 4'(MAX_TERMS) : n_terms;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lfsr    <= 8'h01;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_nterms  <= '0;
            r_disp    <= '0;
            r_correct <= 1'b0;
            r_wrong   <= 1'b0;
            r_timeout <= 1'b0;
            r_score   <= '0;
        end else begin
            r_lfsr    <= w_lfsr_nxt;
            r_correct <= 1'b0;
            r_wrong   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_lfsr   <= (seed == 8'h00) ? 8'h01 : seed;
                        r_nterms <= w_nclamp;
                        r_idx    <= '0;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= SHOW;
                    end
                end
                SHOW: begin
                    // Operand is latched on the first SHOW clock from the freshly stepped LFSR.
                    if (r_cnt == '0) begin
                        r_disp <= 8'(w_lfsr_nxt[NUM_W-1:0]);
                        r_acc  <= r_acc + ACC_W'(w_lfsr_nxt[NUM_W-1:0]);
                    end
                    if (r_cnt == CNT_W'(TERM_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_disp  <= '0;
                        r_state <= GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    r_cnt <= '0;
                    if (r_idx < r_nterms - 4'd1) begin
                        r_idx   <= r_idx + 4'd1;
                        r_state <= SHOW;
                    end else begin
                        r_state <= WAIT_ANS;
                    end
                end
                WAIT_ANS: begin
                    r_disp <= answer;
                    // An answer on the last allowed clock beats the timeout.
                    if (answer_valid) begin
                        if (answer == w_mod) begin
                            r_correct <= 1'b1;
                            if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + 1'b1;
                        end else begin
                            r_wrong <= 1'b1;
                        end
                        r_disp  <= w_mod;
                        r_cnt   <= '0;
                        r_state <= RESULT;
                    end else if (r_cnt == CNT_W'(ANS_CYC - 1)) begin
                        r_timeout <= 1'b1;
                        r_disp    <= w_mod;
                        r_cnt     <= '0;
                        r_state   <= RESULT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESULT: begin
                    r_disp <= w_mod;
                    if (r_cnt == CNT_W'(RES_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_disp  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = (r_state != IDLE);
    assign disp_value = r_disp;
    assign correct    = r_correct;
    assign wrong      = r_wrong;
    assign timeout    = r_timeout;
    assign score      = r_score;

    assign w_clip    = (r_disp > 8'd99) ? 8'd99 : r_disp;
    assign bcd_tens  = 4'(w_clip / 8'd10);
    assign bcd_units = 4'(w_clip % 8'd10);
endmodule

// File: tb/tb_mental_sum_engine.sv
// Directed bench for mental_sum_engine: walks whole rounds clock by clock and
// checks operands, phase lengths, grading, score saturation and async reset.
module tb_mental_sum_engine;
    localparam int NUM_W = 5, MAX_TERMS = 8, TERM_CYC = 10, ANS_CYC = 40;
    localparam int RES_CYC = 10, MOD = 100, SCORE_W = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [3:0]         n_terms = '0;
    logic [7:0]         seed = '0;
    logic [7:0]         answer = '0;
    logic               answer_valid = 1'b0;
    logic               busy;
    logic [7:0]         disp_value;
    logic [3:0]         bcd_tens, bcd_units;
    logic               correct, wrong, timeout;
    logic [SCORE_W-1:0] score;

    int         nvec = 0;
    int         nerr = 0;
    int         exp_score = 0;
    logic [7:0] lf = 8'h01;
    logic [7:0] obs_first;

    mental_sum_engine #(
        .NUM_W(NUM_W), .MAX_TERMS(MAX_TERMS), .TERM_CYC(TERM_CYC), .ANS_CYC(ANS_CYC),
        .RES_CYC(RES_CYC), .MOD(MOD), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_terms(n_terms), .seed(seed),
        .answer(answer), .answer_valid(answer_valid), .busy(busy),
        .disp_value(disp_value), .bcd_tens(bcd_tens), .bcd_units(bcd_units),
        .correct(correct), .wrong(wrong), .timeout(timeout), .score(score)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Reference LFSR advances in lockstep with every rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
        lf = step(lf);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 correct answer, 1 wrong answer, 2 timeout, 3 correct on last WAIT clock
    task automatic run_round(input logic [7:0] sd, input logic [3:0] nt, input int mode);
        int         cnt;
        int         sum;
        logic [7:0] m;
        logic [7:0] op;
        cnt = (nt == 0) ? 1 : ((nt > MAX_TERMS) ? MAX_TERMS : int'(nt));
        sum = 0;
        answer = 8'hEE;
        seed = sd; n_terms = nt; start = 1'b1;
        tick;
        lf = (sd == 8'h00) ? 8'h01 : sd;
        start = 1'b0;
        check("busy_show", busy, 1);
        for (int k = 0; k < cnt; k++) begin
            if (k == 0) answer_valid = 1'b1;
            tick;
            answer_valid = 1'b0;
            op = {3'b000, lf[4:0]};
            sum += op;
            check("operand", disp_value, op);
            if (k == 0) begin
                obs_first = disp_value;
                check("stray_answer", {correct, wrong, timeout}, 0);
            end
            repeat (TERM_CYC - 1) tick;
            check("gap_disp", disp_value, 0);
            check("gap_busy", busy, 1);
            tick;
        end
        m = 8'(sum % MOD);
        tick;
        check("wait_echo", disp_value, 8'hEE);
        check("wait_busy", busy, 1);
        case (mode)
            0, 1: begin
                answer = (mode == 0) ? m : m + 8'd1;
                answer_valid = 1'b1;
                tick;
                answer_valid = 1'b0;
            end
            2: begin
                repeat (ANS_CYC - 2) tick;
                check("no_early_timeout", timeout, 0);
                tick;
            end
            default: begin
                repeat (ANS_CYC - 2) tick;
                answer = m;
                answer_valid = 1'b1;
                tick;
                answer_valid = 1'b0;
            end
        endcase
        if ((mode == 0 || mode == 3) && exp_score < 7) exp_score++;
        check("correct", correct, (mode == 0 || mode == 3));
        check("wrong", wrong, (mode == 1));
        check("timeout", timeout, (mode == 2));
        check("score", score, exp_score);
        check("result_disp", disp_value, m);
        check("bcd_tens", bcd_tens, m / 10);
        check("bcd_units", bcd_units, m % 10);
        tick;
        check("pulse_one_cycle", {correct, wrong, timeout}, 0);
        repeat (RES_CYC - 1) tick;
        check("idle_busy", busy, 0);
        check("idle_disp", disp_value, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_disp", disp_value, 0);
        check("rst_score", score, 0);
        check("rst_pulses", {correct, wrong, timeout}, 0);
        rst = 1'b0;
        tick;

        run_round(8'hA5, 4'd3, 0);
        run_round(8'h00, 4'd0, 0);
        check("seed0_first_op", obs_first, 8'h02);
        run_round(8'h3C, 4'd15, 1);
        run_round(8'h5A, 4'd2, 2);
        run_round(8'h77, 4'd1, 3);

        rst = 1'b1;
        #2;
        rst = 1'b0;
        exp_score = 0;
        tick;
        for (int i = 0; i < 8; i++) run_round(8'h11 + 8'(i), 4'd1, 0);
        check("score_saturated", score, 7);

        seed = 8'hC3; n_terms = 4'd5; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (2 * (TERM_CYC + 1) + 3) tick;
        check("mid_show_busy", busy, 1);
        rst = 1'b1;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_disp", disp_value, 0);
        check("mid_rst_score", score, 0);
        check("mid_rst_bcd", {bcd_tens, bcd_units}, 0);
        rst = 1'b0;
        exp_score = 0;
        tick;
        run_round(8'hC3, 4'd5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mental_sum_engine.md
MENTAL_SUM_ENGINE -- requirements
Module: mental_sum_engine

Interface
REQ-001 SHALL have parameter NUM_W, default 5, operand width in bits (legal 3..8).
REQ-002 SHALL have parameter MAX_TERMS, default 8, maximum operands per round (legal 2..8).
REQ-003 SHALL have parameter TERM_CYC, default 10, clocks each operand is displayed.
REQ-004 SHALL have parameter ANS_CYC, default 40, clocks allowed for an answer before timeout.
REQ-005 SHALL have parameter RES_CYC, default 10, clocks the result is displayed.
REQ-006 SHALL have parameter MOD, default 100, modulus applied to the sum (legal 2..100).
REQ-007 SHALL have parameter SCORE_W, default 3, score counter width.
REQ-008 clk  input  1  clock, all state updates on rising edge.
REQ-009 rst  input  1  reset, asynchronous, active-high.
REQ-010 start  input  1  begin a round; sampled only in IDLE.
REQ-011 n_terms  input  4  requested operand count; sampled with start.
REQ-012 seed  input  8  LFSR seed; sampled with start.
REQ-013 answer  input  8  player answer.
REQ-014 answer_valid  input  1  one-cycle answer strobe.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 disp_value  output  8  registered value to display.
REQ-017 bcd_tens, bcd_units  output  4 each  decimal digits of min(disp_value,99), combinational from disp_value.
REQ-018 correct, wrong, timeout  output  1 each  one-cycle result pulses.
REQ-019 score  output  SCORE_W  count of correct answers.

Function
REQ-020 SHALL implement states IDLE, SHOW, GAP, WAIT_ANS, RESULT.
REQ-021 SHALL contain an 8-bit Fibonacci LFSR stepping every clock: shift left, new bit0 = b7^b5^b4^b3.
REQ-022 On start in IDLE, SHALL load LFSR with seed, substituting 8'h01 when seed==0; next state SHOW, term index 0, sum 0.
REQ-023 SHALL clamp n_terms: 0 -> 1, values > MAX_TERMS -> MAX_TERMS; the clamped count is held for the round.
REQ-024 On SHOW entry, SHALL capture operand = LFSR[NUM_W-1:0], set disp_value to it zero-extended, add it to an (NUM_W+4)-bit accumulator.
REQ-025 SHALL stay in SHOW for exactly TERM_CYC clocks, then GAP for exactly 1 clock with disp_value=0.
REQ-026 After GAP, SHALL return to SHOW if term index < count-1 (index increments), else enter WAIT_ANS.
REQ-027 In WAIT_ANS, disp_value SHALL follow answer each clock (1-cycle registered echo).
REQ-028 answer_valid in WAIT_ANS: compare answer against accumulator mod MOD; equal -> correct pulse and score+1 saturating at 2^SCORE_W-1; else wrong pulse; then RESULT.
REQ-029 If ANS_CYC clocks elapse in WAIT_ANS without answer_valid, SHALL pulse timeout, leave score unchanged, enter RESULT.
REQ-030 answer_valid on the same clock as the final WAIT_ANS count SHALL be treated as an answer, not a timeout.
REQ-031 In RESULT, disp_value SHALL be accumulator mod MOD for RES_CYC clocks, then IDLE with disp_value=0.
REQ-032 start outside IDLE and answer_valid outside WAIT_ANS SHALL be ignored.
REQ-033 Exactly one of correct/wrong/timeout SHALL pulse per round.

Reset
REQ-034 rst SHALL force state IDLE, disp_value=0, score=0, correct=wrong=timeout=0, busy=0, LFSR=8'h01, accumulator and counters 0, at any time including mid-round.
REQ-035 score SHALL persist across rounds; only rst clears it.

Verification
REQ-036 start, n_terms=3, seed=8'hA5, answer = mod-100 sum of the three captured disp_value operands -> busy high 3*(TERM_CYC+1) clocks before WAIT_ANS, correct pulse, score=1, RESULT shows that sum.
REQ-037 start with seed=0, n_terms=0 -> first operand = 8'h01 stepped once per REQ-021 rule (LFSR value 8'h02 -> operand 2), exactly one SHOW phase.
REQ-038 n_terms=15, MAX_TERMS=8 -> exactly 8 SHOW phases; wrong answer (sum+1) -> wrong pulse, score unchanged.
REQ-039 no answer_valid in WAIT_ANS -> timeout pulse exactly ANS_CYC clocks after WAIT_ANS entry; answer_valid on that clock -> correct/wrong instead.
REQ-040 8 consecutive correct rounds, SCORE_W=3 -> score 1..7 then stays 7.
REQ-041 rst asserted mid-SHOW of term 2 -> immediate IDLE, disp_value=0, score=0; next start runs a clean round.
